// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the CPU load/store port.
// Accepts one request at a time over req/ack, waits WAIT_CYCLES cycles, then
// performs a byte/half/word access with little-endian lanes.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   req           request valid, sampled only in IDLE
//   we            1 = store, 0 = load
//   addr          byte address
//   wdata         right-aligned store data
//   size          00 byte, 01 half, 10 word, 11 illegal
//   load_unsigned 1 = zero-extend sub-word loads, 0 = sign-extend
//   busy          transaction in progress
//   ack           one-cycle completion pulse
//   err           error status, valid with ack
//   rdata         load result
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [32:0] LIMIT     = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        lu_q;

  logic [31:0] mem [DEPTH];

  logic                  cur_we;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [1:0]            cur_size;
  logic                  cur_lu;
  logic [31:0]           offset;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  acc_err;
  logic                  enter_resp;
  logic [3:0]            be;
  logic [31:0]           wsh;
  logic [31:0]           rword;
  logic [31:0]           rsh;
  logic [31:0]           load_val;

  // With WAIT_CYCLES = 0 the access happens on the accept edge itself, so the
  // decode must see the live inputs in IDLE and the captured copy afterwards.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_size  = size;
      cur_lu    = load_unsigned;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_size  = size_q;
      cur_lu    = lu_q;
    end
  end

  always_comb begin
    offset = cur_addr - BASE_ADDR;
    lane   = offset[1:0];
    idx    = offset[ADDR_WIDTH+1:2];
    case (cur_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = lane[0];
      2'b10:   acc_err = (lane != 2'b00);
      default: acc_err = 1'b1;
    endcase
    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
    if ({1'b0, offset} >= LIMIT) acc_err = 1'b1;

    enter_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                 ((state == WAIT) && (cnt == 4'd0));

    case (cur_size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    wsh = cur_wdata << {lane, 3'b000};

    rword = mem[idx];
    rsh   = rword >> {lane, 3'b000};
    case (cur_size)
      2'b00:   load_val = {{24{~cur_lu & rsh[7]}}, rsh[7:0]};
      2'b01:   load_val = {{16{~cur_lu & rsh[15]}}, rsh[15:0]};
      default: load_val = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      lu_q    <= 1'b0;
    end else begin
      if (enter_resp) begin
        err   <= acc_err;
        rdata <= (acc_err || cur_we) ? 32'd0 : load_val;
      end
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size;
            lu_q    <= load_unsigned;
            busy    <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
              ack   <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder. One instance runs
// with WAIT_CYCLES = 2, a second with WAIT_CYCLES = 0; both share the request
// fields but have separate req lines.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size = '0;
  logic        load_unsigned = 1'b0;

  logic        busy_a, ack_a, err_a;
  logic [31:0] rdata_a;
  logic        busy_b, ack_b, err_b;
  logic [31:0] rdata_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic        e;
    logic [31:0] d;
  } exp_t;
  exp_t sbq[$];

  // Byte-wide reference memory covering the 4 KiB window.
  logic [7:0] mb [4096];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .load_unsigned(load_unsigned),
    .busy(busy_a), .ack(ack_a), .err(err_a), .rdata(rdata_a)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .load_unsigned(load_unsigned),
    .busy(busy_b), .ack(ack_b), .err(err_b), .rdata(rdata_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic lu,
                       output logic e, output logic [31:0] d);
    int n;
    int base;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
        (a >= 32'h0000_1000);
    d = '0;
    base = int'(a[11:0]);
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) d[8*i +: 8] = mb[base + i];
        if (!lu && sz == 2'd0 && d[7])  d[31:8]  = '1;
        if (!lu && sz == 2'd1 && d[15]) d[31:16] = '1;
      end
    end
  endtask

  function automatic logic get_ack(input bit sel);
    return sel ? ack_b : ack_a;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // sel picks the instance; glitch re-raises req with junk store fields while busy.
  task automatic do_op(input bit sel, input bit glitch, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic lu);
    exp_t ex;
    exp_t got;
    int n;
    model(w, a, wd, sz, lu, ex.e, ex.d);
    sbq.push_back(ex);
    @(negedge clk);
    we = w; addr = a; wdata = wd; size = sz; load_unsigned = lu;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk); #1;
    n = 1;
    chk("busy_after_accept", {31'd0, get_busy(sel)}, 32'd1);
    if (glitch) begin
      if (sel) req_b = 1'b0; else req_a = 1'b0;
      @(negedge clk);
      we = 1'b1; addr = 32'h10; wdata = 32'h0; size = 2'd2;
      if (sel) req_b = 1'b1; else req_a = 1'b1;
      #1;
    end
    while (!get_ack(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!get_ack(sel)) begin
      chk("ack_timeout", 32'd0, 32'd1);
      void'(sbq.pop_front());
    end else begin
      chk("ack_latency", n, sel ? 32'd1 : 32'd3);
      chk("busy_in_resp", {31'd0, get_busy(sel)}, 32'd1);
      got = sbq.pop_front();
      chk("err", {31'd0, sel ? err_b : err_a}, {31'd0, got.e});
      chk("rdata", sel ? rdata_b : rdata_a, got.d);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, get_ack(sel)}, 32'd0);
    chk("busy_idle", {31'd0, get_busy(sel)}, 32'd0);
    if (glitch) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        chk("no_extra_ack", {31'd0, get_ack(sel)}, 32'd0);
      end
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_ack", {31'd0, ack_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    do_op(0, 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0);
    do_op(0, 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    do_op(0, 0, 1'b1, 32'h13, 32'h80, 2'd0, 1'b0);
    do_op(0, 0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
    do_op(0, 0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1);
    do_op(0, 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    do_op(0, 0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0);
    do_op(0, 0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b1);
    do_op(0, 0, 1'b1, 32'h11, 32'hFFFF, 2'd1, 1'b0);
    do_op(0, 0, 1'b1, 32'h12, 32'h1111_2222, 2'd2, 1'b0);
    do_op(0, 0, 1'b1, 32'h10, 32'h3333_4444, 2'd3, 1'b0);
    do_op(0, 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    do_op(0, 0, 1'b0, 32'h0000_1000, 32'h0, 2'd2, 1'b0);
    do_op(0, 0, 1'b0, 32'hFFFF_FFFC, 32'h0, 2'd2, 1'b0);
    do_op(0, 0, 1'b1, 32'hFFC, 32'h8765_4321, 2'd2, 1'b0);
    do_op(0, 0, 1'b0, 32'hFFC, 32'h0, 2'd2, 1'b0);
    do_op(0, 0, 1'b0, 32'hFFF, 32'h0, 2'd0, 1'b0);
    do_op(0, 0, 1'b0, 32'hFFE, 32'h0, 2'd1, 1'b1);
    do_op(0, 0, 1'b1, 32'h12, 32'hA5A5, 2'd1, 1'b0);
    do_op(0, 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);

    // Glitching req while busy must not spawn a second transaction.
    do_op(0, 1, 1'b1, 32'h30, 32'h0BAD_CAFE, 2'd2, 1'b0);
    do_op(0, 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    do_op(0, 0, 1'b0, 32'h30, 32'h0, 2'd2, 1'b0);

    // Abort a store during WAIT; memory must keep the old word.
    do_op(0, 0, 1'b1, 32'h20, 32'hCAFE_F00D, 2'd2, 1'b0);
    do_op(0, 0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; size = 2'd2; req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_ack", {31'd0, ack_a}, 32'd0);
    chk("abort_rdata", rdata_a, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", {31'd0, ack_a}, 32'd0);
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_ack", {31'd0, ack_a}, 32'd0);
    end
    do_op(0, 0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);

    // Zero-wait instance; uses a fresh address so its separate array matches the model.
    do_op(1, 0, 1'b1, 32'h40, 32'h0F1E_2D3C, 2'd2, 1'b0);
    do_op(1, 0, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
    do_op(1, 0, 1'b0, 32'h41, 32'h0, 2'd0, 1'b0);
    do_op(1, 1, 1'b0, 32'h42, 32'h0, 2'd1, 1'b0);

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp %0d", 0, 1);
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the CPU's load/store port. It accepts one request at a time over a req/ack handshake and waits a programmable number of cycles, then performs the access.
- Supports byte, half and word sizes, little-endian lanes, and sign- or zero-extension of sub-word loads. Misaligned, out-of-range and illegal-size requests are flagged.
- Replaces the single-cycle mem block when the core moves to a multi-cycle or stalling memory interface.

Parameters:
- ADDR_WIDTH, 10, word-address bits. Depth is 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2, extra cycles between accept and ack. Legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  request valid. Sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- load_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- busy  out  1  transaction in progress.
- ack  out  1  one-cycle completion pulse.
- err  out  1  error status. Valid only while ack = 1.
- rdata  out  32  load result.

Behaviour:
- Clock is clk. Reset is rst: asynchronous and active-low.
- Reset state:
  - FSM in IDLE, wait counter = 0.
  - busy = 0, ack = 0, err = 0, rdata = 0.
  - Memory array is not reset.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: if req = 1 at a rising edge, the request is accepted. we, addr, wdata, size and load_unsigned are captured in that edge.
    - Next state is WAIT with counter = WAIT_CYCLES-1 when WAIT_CYCLES > 0.
    - Next state is RESP when WAIT_CYCLES = 0.
  - WAIT: counter decrements each edge. At counter = 0 the next state is RESP.
  - RESP: ack = 1 for exactly one cycle, then IDLE.
- The array write and the rdata/err update happen on the edge that enters RESP.
- Timing: ack is high in the cycle after edge (accept edge + WAIT_CYCLES + 1). Load latency is WAIT_CYCLES+1 cycles.
- busy is 1 from the cycle after the accept edge through the RESP cycle inclusive. busy is 0 in IDLE.
- req is ignored while busy. No queueing.
- The initiator holds request fields stable through acceptance and deasserts req in the ack cycle. req = 1 in IDLE afterwards is a new request.
- Throughput is one request per WAIT_CYCLES+2 cycles.
- Address decode:
  - offset = addr - BASE_ADDR. Word index = offset[ADDR_WIDTH+1:2]. Lane = offset[1:0].
  - Out of range when offset >= 4*2**ADDR_WIDTH, using unsigned 32-bit compare with wrap.
- Error conditions: size = 11, half with lane[0] = 1, word with lane != 00, or out of range.
  - On error: err = 1 with ack, no array write, rdata = 0.
- Stores:
  - Byte writes wdata[7:0] into lane byte addr[1:0].
  - Half writes wdata[15:0] into bytes lane..lane+1.
  - Word writes all 32 bits.
  - Unselected bytes are unchanged.
  - On a store ack: err = 0, rdata = 0.
- Loads:
  - Byte: selected byte extended to 32 bits.
  - Half: selected halfword extended to 32 bits.
  - Extension is sign or zero per load_unsigned.
  - Word: load_unsigned is ignored.
- rdata and err hold their values until the next RESP entry.
- Reset mid-transaction: the transaction is aborted. If reset asserts before the RESP-entry edge, the store is not performed. No ack is issued.

Test Plan:
- WAIT_CYCLES=2, store word 0xDEADBEEF at 0x10, then load word 0x10:
  - busy rises the cycle after accept.
  - ack is high exactly 3 edges after accept, err = 0.
  - rdata = 0xDEADBEEF on the load ack.
- After the prior test, store byte 0x80 at 0x13:
  - load signed byte 0x13 gives 0xFFFFFF80.
  - load unsigned byte 0x13 gives 0x00000080.
  - load word 0x10 gives 0x80ADBEEF.
- Load half signed 0x12 gives 0xFFFF80AD. Load half unsigned 0x12 gives 0x000080AD.
- Store half at 0x11, store word at 0x12, and size = 11:
  - each gives ack with err = 1 and rdata = 0.
  - subsequent load word 0x10 is still 0x80ADBEEF.
- Load at 0x00001000 (ADDR_WIDTH=10) gives err = 1.
- Loads at 0x00000FFC succeed.
- Reset mid-operation: accept store word 0x12345678 at 0x20, then pull rst low during WAIT.
  - No ack is issued.
  - Outputs go to 0 immediately (asynchronous reset).
  - After release, load 0x20 returns the pre-existing contents, not 0x12345678.
- Busy behaviour and WAIT_CYCLES=0:
  - Raise req while busy: it is ignored with no extra ack.
  - With WAIT_CYCLES=0, ack appears 1 edge after accept.
